// File: rtl/int4_dot_accum_if.sv
// int4_dot_accum_if
//   Bundles the beat input channel and the result output channel of
//   int4_dot_accum.
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high. A producer holds its payload stable while valid is high and
//   ready is low. Ready may depend combinationally on the consumer state.
//   Signals:
//     in_valid/in_ready/in_act/in_wgt/in_last : beat channel into the block
//     out_valid/out_ready/out_val/out_sat/out_terms : result channel out
//   Modports:
//     master : upstream/downstream environment (drives beats, out_ready)
//     slave  : the accumulator itself
interface int4_dot_accum_if #(
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*LANES-1:0]     in_act;
  logic [4*LANES-1:0]     in_wgt;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [14:0]     out_val;
  logic                   out_sat;
  logic [7:0]             out_terms;

  modport master (
    output in_valid, in_act, in_wgt, in_last, out_ready,
    input  in_ready, out_valid, out_val, out_sat, out_terms
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last, out_ready,
    output in_ready, out_valid, out_val, out_sat, out_terms
  );
endinterface

// File: rtl/int4_dot_accum.sv
// int4_dot_accum
//   Streaming int4 dot-product accumulator. Each accepted beat carries LANES
//   signed int4 activation/weight pairs. S1 registers the per-lane products,
//   S2 registers their sum, S3 accumulates with saturation to 15 bits until a
//   beat flagged last, then loads the group result into the output register.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : int4_dot_accum_if.slave (beat channel in, result channel out)
//   The whole pipeline advances only when the output register can accept a
//   new value (adv = ~out_valid | out_ready); in_ready equals adv.
module int4_dot_accum #(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  int4_dot_accum_if.slave   bus
);
  localparam int PW = 8 + $clog2(LANES);
  localparam logic signed [16:0] MAX_V = 17'sd16383;
  localparam logic signed [16:0] MIN_V = -17'sd16384;

  // Stage registers
  logic signed [7:0]    prod_q [LANES];
  logic signed [7:0]    prod_d [LANES];
  logic                 v1_q, last1_q;
  logic signed [PW-1:0] psum_q, psum_d;
  logic                 v2_q, last2_q;

  // Accumulator state
  logic signed [14:0]   acc_q;
  logic                 sticky_q;
  logic [7:0]           cnt_q;

  // Output register
  logic                 out_valid_q;
  logic signed [14:0]   out_val_q;
  logic                 out_sat_q;
  logic [7:0]           out_terms_q;

  logic                 adv;
  logic signed [16:0]   sum_d;
  logic                 clamp_now;
  logic signed [14:0]   nxt;
  logic [7:0]           cnt_inc;

  assign adv = ~out_valid_q | bus.out_ready;

  // Per-lane 4x4 signed products; sign-extending casts keep the multiply signed.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = 8'($signed(bus.in_act[4*i +: 4])) * 8'($signed(bus.in_wgt[4*i +: 4]));
    end
  end

  always_comb begin
    psum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      psum_d = psum_d + PW'(prod_q[i]);
    end
  end

  // 17 bits holds acc + psum without overflow for every legal LANES.
  always_comb begin
    sum_d     = 17'(acc_q) + 17'(psum_q);
    clamp_now = (sum_d > MAX_V) || (sum_d < MIN_V);
    if (sum_d > MAX_V)      nxt = 15'sh3fff;
    else if (sum_d < MIN_V) nxt = 15'sh4000;
    else                    nxt = sum_d[14:0];
    cnt_inc = (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      psum_q      <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_sat_q   <= 1'b0;
      out_terms_q <= '0;
    end else if (adv) begin
      // in_ready == adv here, so in_valid alone marks an accepted beat.
      prod_q  <= prod_d;
      v1_q    <= bus.in_valid;
      last1_q <= bus.in_last;
      psum_q  <= psum_d;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      // adv means the held result (if any) is consumed this edge.
      out_valid_q <= v2_q & last2_q;
      if (v2_q) begin
        if (last2_q) begin
          out_val_q   <= nxt;
          out_sat_q   <= sticky_q | clamp_now;
          out_terms_q <= cnt_inc;
          acc_q       <= '0;
          sticky_q    <= 1'b0;
          cnt_q       <= '0;
        end else begin
          acc_q       <= nxt;
          sticky_q    <= sticky_q | clamp_now;
          cnt_q       <= cnt_inc;
        end
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_terms = out_terms_q;
endmodule

// File: tb/tb_int4_dot_accum.sv
module tb_int4_dot_accum;
  localparam int LANES = 4;
  localparam int W = 24;  // {val[14:0], sat, terms[7:0]}

  typedef struct {
    logic [15:0] act;
    logic [15:0] wgt;
    int          exp_val;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int4_dot_accum_if #(.LANES(LANES)) bus ();
  int4_dot_accum #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got, mon_exp;
  vec_t vecs[6];

  // Scoreboard: a result is consumed at the edge after a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_val, bus.out_sat, bus.out_terms};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got val=%0d sat=%0d terms=%0d, none expected",
                 $signed(mon_got[23:9]), mon_got[8], mon_got[7:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL result: got val=%0d sat=%0d terms=%0d expected val=%0d sat=%0d terms=%0d",
                   $signed(mon_got[23:9]), mon_got[8], mon_got[7:0],
                   $signed(mon_exp[23:9]), mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int val, input logic sat, input int terms);
    exp_q.push_back({15'(val), sat, 8'(terms)});
  endtask

  // Holds the beat until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [15:0] act, input logic [15:0] wgt, input logic last);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.in_act   = act;
    bus.in_wgt   = wgt;
    bus.in_last  = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles", n);
    end
  endtask

  // Idle cycles carry junk payload that must be ignored.
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_act   = 16'($urandom_range(0, 65535));
    bus.in_wgt   = 16'($urandom_range(0, 65535));
    bus.in_last  = 1'($urandom_range(0, 1));
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_group(input logic [15:0] act, input logic [15:0] wgt, input int n,
                           input int ev, input logic es, input int et);
    push_exp(ev, es, et);
    for (int i = 0; i < n; i++) send(act, wgt, (i == n - 1));
    idle(0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single-beat groups, hand-computed (lane 0 in the low nibble).
    vecs[0] = '{16'h4321, 16'h1111, 10};    // 1+2+3+4
    vecs[1] = '{16'h8888, 16'h7777, -224};  // 4 * (-8*7)
    vecs[2] = '{16'h8888, 16'h8888, 256};   // 4 * (-8*-8)
    vecs[3] = '{16'h30F7, 16'hE577, 36};    // 49 - 7 + 0 - 6
    vecs[4] = '{16'h0000, 16'h0000, 0};
    vecs[5] = '{16'hFFFF, 16'h4321, -10};   // -(1+2+3+4)

    // Clock/reset
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_out_terms", bus.out_terms, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Latency of a single-beat group: result visible after edge k+2 only.
    push_exp(10, 1'b0, 1);
    send(16'h4321, 16'h1111, 1'b1);
    idle(0);
    @(negedge clk); check("lat_k", bus.out_valid, 0);
    @(negedge clk); check("lat_k1", bus.out_valid, 0);
    @(negedge clk); check("lat_k2_valid", bus.out_valid, 1);
    check("lat_k2_val", bus.out_val, 10);
    @(negedge clk); check("lat_k3", bus.out_valid, 0);
    @(posedge clk);
    #1;
    drain("latency");

    // Table: back-to-back single-beat groups, one result per cycle.
    foreach (vecs[i]) begin
      push_exp(vecs[i].exp_val, 1'b0, 1);
      send(vecs[i].act, vecs[i].wgt, 1'b1);
    end
    idle(0);
    drain("table");

    // Positive saturation
    run_group(16'h8888, 16'h8888, 63, 16128, 1'b0, 63);
    run_group(16'h8888, 16'h8888, 64, 16383, 1'b1, 64);
    drain("pos_sat");

    // Negative saturation, then a clean group
    run_group(16'h8888, 16'h7777, 73, -16352, 1'b0, 73);
    run_group(16'h8888, 16'h7777, 74, -16384, 1'b1, 74);
    run_group(16'h0001, 16'h0003, 1, 3, 1'b0, 1);
    drain("neg_sat");

    // Backpressure: results 1..6, output held 5 cycles after the first.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          push_exp(k, 1'b0, 1);
          send(16'h0001, 16'(k), 1'b1);
        end
        idle(0);
      end
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", bus.out_valid, 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 0);
          check("bp_hold_val", bus.out_val, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset mid-group discards the partial sum and in-flight beats.
    for (int i = 0; i < 3; i++) send(16'h1111, 16'h1111, 1'b0);
    idle(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_group(16'h0002, 16'h0005, 1, 10, 1'b0, 1);
    drain("reset_mid");

    // Bubbles between beats of one group
    push_exp(32, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      send(16'h1111, 16'h2222, (i == 3));
      idle(1);
    end
    drain("bubbles");

    // Long group: term count saturates
    run_group(16'h0000, 16'h0000, 300, 0, 1'b0, 255);
    drain("long");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
